// File: rtl/add_serial_keyed.sv
// Bit-serial adder/subtractor whose control FSM detours through a chain of
// decoy states that rotate operand A whenever the unlock key is wrong.
module add_serial_keyed #(
   parameter int                   WIDTH     = 8,
   parameter int                   KEY_WIDTH = 8,
   parameter logic [KEY_WIDTH-1:0] KEY       = 8'hA5,
   parameter int                   NUM_DECOY = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 sub,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   input  logic [KEY_WIDTH-1:0] key,
   output logic                 busy,
   output logic                 done,
   output logic [WIDTH-1:0]     out,
   output logic                 cout,
   output logic                 ovf
);

   localparam int CW = $clog2(WIDTH);
   localparam int SW = $clog2(NUM_DECOY + 3);
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
   localparam logic [SW-1:0] LAST_DECOY = SW'(NUM_DECOY + 2);

   // Decoy states occupy the encodings from S_DECOY0 upward, one per decoy.
   typedef enum logic [SW-1:0] {
      S_IDLE   = SW'(0),
      S_ADD    = SW'(1),
      S_DONE   = SW'(2),
      S_DECOY0 = SW'(3)
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] aReg_q, aReg_d;
   logic [WIDTH-1:0] bReg_q, bReg_d;
   logic             carry_q, carry_d;
   logic [CW-1:0]    count_q, count_d;
   logic [WIDTH-1:0] out_q, out_d;
   logic             cout_q, cout_d;
   logic             ovf_q, ovf_d;
   logic             sumBit;
   logic             newCarry;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = (key == KEY) ? S_ADD : S_DECOY0;
            end
         end
         S_ADD: begin
            if (count_q == LAST_BIT) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = (state_q == LAST_DECOY) ? S_ADD : state_t'(state_q + SW'(1));
         end
      endcase
   end

   always_comb begin
      busy = (state_q != S_IDLE);
      done = (state_q == S_DONE);
      out  = out_q;
      cout = cout_q;
      ovf  = ovf_q;
   end

   // Subtraction is a + ~b + 1, so the inverted B and the seeded carry do the work.
   always_comb begin
      sumBit   = aReg_q[0] ^ bReg_q[0] ^ carry_q;
      newCarry = (aReg_q[0] & bReg_q[0]) | (aReg_q[0] & carry_q) | (bReg_q[0] & carry_q);
      aReg_d   = aReg_q;
      bReg_d   = bReg_q;
      carry_d  = carry_q;
      count_d  = count_q;
      out_d    = out_q;
      cout_d   = cout_q;
      ovf_d    = ovf_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               aReg_d  = a;
               bReg_d  = sub ? ~b : b;
               carry_d = sub;
               count_d = '0;
               out_d   = '0;
               cout_d  = 1'b0;
               ovf_d   = 1'b0;
            end
         end
         S_ADD: begin
            out_d   = {sumBit, out_q[WIDTH-1:1]};
            aReg_d  = aReg_q >> 1;
            bReg_d  = bReg_q >> 1;
            carry_d = newCarry;
            count_d = count_q + CW'(1);
            if (count_q == LAST_BIT) begin
               cout_d = newCarry;
               ovf_d  = carry_q ^ newCarry;
            end
         end
         S_DONE: begin
         end
         default: begin
            aReg_d = {aReg_q[0], aReg_q[WIDTH-1:1]};
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         aReg_q  <= '0;
         bReg_q  <= '0;
         carry_q <= 1'b0;
         count_q <= '0;
         out_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         aReg_q  <= aReg_d;
         bReg_q  <= bReg_d;
         carry_q <= carry_d;
         count_q <= count_d;
         out_q   <= out_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
      end
   end

endmodule

// File: doc/add_serial_keyed.md
# add_serial_keyed

Parametrised bit-serial adder/subtractor with a key-locked control FSM. It is the next generation of the team's serial-add block. It adds WIDTH generalisation, a subtract mode, a start/busy/done handshake, carry-out and signed-overflow flags, and a configurable chain of decoy states. Those decoy states corrupt the result deterministically unless the correct key is presented at start. It sits in the control-obfuscation benchmark set as a locked datapath under test.

## Interface
- WIDTH, 8: operand/result width in bits; legal values ≥ 2.
- KEY_WIDTH, 8: width of the key input.
- KEY, 8'hA5: correct unlock key, KEY_WIDTH bits.
- NUM_DECOY, 4: number of decoy states; legal values ≥ 1.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  request; sampled only in IDLE.
- sub  in  1  0 = a+b, 1 = a−b; sampled with start.
- a  in  WIDTH  operand A; sampled with start.
- b  in  WIDTH  operand B; sampled with start.
- key  in  KEY_WIDTH  unlock key; sampled with start.
- busy  out  1  high whenever the state is not IDLE.
- done  out  1  one-cycle pulse; high only in DONE.
- out  out  WIDTH  result, LSB-first shift register.
- cout  out  1  final carry (for sub: 1 = no borrow).
- ovf  out  1  two's-complement overflow.

## Operation
- States: IDLE, DECOY_0..DECOY_{NUM_DECOY−1}, ADD, DONE. Binary encoding uses clog2(NUM_DECOY+3) bits.
- Internal registers:
  - a_reg, b_reg: WIDTH bits each.
  - carry: 1 bit.
  - count: clog2(WIDTH) bits.
- IDLE with start=1:
  - a_reg←a; b_reg←(sub ? ~b : b); carry←sub; count←0.
  - out←0; cout←0; ovf←0.
  - Next state: ADD if key==KEY, else DECOY_0.
- IDLE with start=0: hold all registers.
- DECOY_i:
  - a_reg←{a_reg[0], a_reg[WIDTH−1:1]} (rotate right by 1); all other registers hold.
  - Next state: DECOY_{i+1}, or ADD from the last decoy.
  - Net effect of a wrong key: A is rotated right by NUM_DECOY mod WIDTH before the add.
- ADD, one cycle per bit:
  - sum = a_reg[0]^b_reg[0]^carry.
  - out←{sum, out[WIDTH−1:1]}; a_reg←a_reg>>1; b_reg←b_reg>>1.
  - carry←majority(a_reg[0], b_reg[0], carry); count←count+1.
  - When count==WIDTH−1: cout←new carry; ovf←carry^new carry (carry into MSB XOR carry out of MSB); next state DONE.
- DONE: done=1 for this cycle; next state IDLE unconditionally.
- Held outputs: out, cout and ovf hold their values until the next accepted start.
- start is ignored while busy, including in DONE. No queuing.
- Arithmetic is modulo 2^WIDTH; there is no saturation.

## Timing
- Reset values: state IDLE, busy 0, done 0, out 0, cout 0, ovf 0. Internal registers also reset to 0.
- Reset mid-operation aborts immediately to the reset values. No done pulse is emitted.
- Correct key: start is sampled at edge E. done is high in the cycle after edge E+WIDTH. The result is valid from that same cycle.
- Wrong key: done is high in the cycle after edge E+WIDTH+NUM_DECOY.
- busy rises in the cycle after edge E and falls in the cycle after DONE.
- Back-to-back operation: the earliest next start is sampled at the edge that leaves DONE+1, i.e. the first IDLE cycle. Minimum issue interval is WIDTH+2 cycles (unlocked).
- Changing a, b, key or sub while busy has no effect.

## Test plan
All scenarios use WIDTH=8, KEY=8'hA5, NUM_DECOY=4.
- Add, key A5, a=3C, b=45 -> out=81, cout=0, ovf=1; done 8 cycles after the start edge, one cycle wide.
- Sub, key A5, a=10, b=20 -> out=F0, cout=0, ovf=0.
- Sub, key A5, a=80, b=01 -> out=7F, cout=1, ovf=1.
- Add, key A5, a=FF, b=01 -> out=00, cout=1, ovf=0. Then a second start in the first IDLE cycle with a=01, b=01 -> out=02.
- Add, key 00, a=01, b=00 -> out=10 (decoy rotation); done 12 cycles after the start edge; busy high throughout.
- Mid-op behaviour:
  - start pulsed again mid-ADD -> ignored; result unchanged.
  - rst asserted during ADD count=3 -> immediate IDLE, all outputs 0, no done pulse.
  - A subsequent start completes normally.
